// File: rtl/csi2_stat_pkg.sv
// Shared widths and the saturating adder used by the CSI-2 statistics accumulator.
package csi2_stat_pkg;

  localparam int STAT_WIDTH = 32;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  // Sum that sticks at STAT_MAX instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value,
                                                    input logic [STAT_WIDTH-1:0] increment);
    logic [STAT_WIDTH:0] sum;
    sum = {1'b0, value} + {1'b0, increment};
    return sum[STAT_WIDTH] ? STAT_MAX : sum[STAT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/csi2_minmax_tracker.sv
// Registered min/max of a sample stream; both outputs read 0 until the first sample
// after reset or clear.
module csi2_minmax_tracker
  import csi2_stat_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic [STAT_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic [STAT_WIDTH-1:0] min_o,
  output logic [STAT_WIDTH-1:0] max_o
);

  logic seen;

  // NOTE: reset is synchronous, so it is just the highest-priority branch of the
  // clocked block; all state here uses non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      seen  <= 1'b0;
      min_o <= '0;
      max_o <= '0;
    end else if (sample_valid_i) begin
      seen <= 1'b1;
      if (!seen || sample_i < min_o) min_o <= sample_i;
      if (!seen || sample_i > max_o) max_o <= sample_i;
    end
  end

endmodule

// File: rtl/csi2_stat_acc.sv
// CSI-2 receiver statistics: error counters, line/pixel extremes and frames per second.
// Define CSI2_STAT_FPS_EN to build the FPS window; otherwise fps_o is tied to 0.
module csi2_stat_acc
  import csi2_stat_pkg::*;
#(
  parameter int PX_PER_CLK  = 4,
  parameter int CLK_FREQ_HZ = 74_250_000
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              clear_stat_i,
  input  logic                              header_err_i,
  input  logic                              corr_header_err_i,
  input  logic                              crc_err_i,
  input  logic                              frame_start_i,
  input  logic                              frame_end_i,
  input  logic                              line_start_i,
  input  logic                              line_end_i,
  input  logic                              px_valid_i,
  input  logic [$clog2(PX_PER_CLK+1)-1:0]   px_cnt_i,
  output logic [STAT_WIDTH-1:0]             header_err_cnt_o,
  output logic [STAT_WIDTH-1:0]             corr_header_err_cnt_o,
  output logic [STAT_WIDTH-1:0]             crc_err_cnt_o,
  output logic [STAT_WIDTH-1:0]             max_ln_per_frame_o,
  output logic [STAT_WIDTH-1:0]             min_ln_per_frame_o,
  output logic [STAT_WIDTH-1:0]             max_px_per_ln_o,
  output logic [STAT_WIDTH-1:0]             min_px_per_ln_o,
  output logic [STAT_WIDTH-1:0]             fps_o
);

  if (CLK_FREQ_HZ < 2) begin : g_freq_check
    $error("CLK_FREQ_HZ must be at least 2");
  end

  localparam logic [STAT_WIDTH-1:0] ONE = STAT_WIDTH'(1);

  // Error counters; clear has priority over a coincident strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_stat_i) begin
      header_err_cnt_o      <= '0;
      corr_header_err_cnt_o <= '0;
      crc_err_cnt_o         <= '0;
    end else begin
      if (header_err_i)      header_err_cnt_o      <= sat_inc(header_err_cnt_o, ONE);
      if (corr_header_err_i) corr_header_err_cnt_o <= sat_inc(corr_header_err_cnt_o, ONE);
      if (crc_err_i)         crc_err_cnt_o         <= sat_inc(crc_err_cnt_o, ONE);
    end
  end

  // Lines per frame.
  logic                  in_frame;
  logic [STAT_WIDTH-1:0] ln_acc;
  logic [STAT_WIDTH-1:0] ln_total;
  logic                  ln_sample_valid;

  // A line ending in the frame_end cycle belongs to the frame being closed.
  assign ln_total        = (line_end_i && in_frame) ? sat_inc(ln_acc, ONE) : ln_acc;
  assign ln_sample_valid = frame_end_i && in_frame;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_frame <= 1'b0;
      ln_acc   <= '0;
    end else if (frame_start_i) begin
      in_frame <= 1'b1;
      ln_acc   <= '0;
    end else if (in_frame) begin
      if (line_end_i)  ln_acc   <= sat_inc(ln_acc, ONE);
      if (frame_end_i) in_frame <= 1'b0;
    end
  end

  // Pixels per line.
  logic                  in_line;
  logic [STAT_WIDTH-1:0] px_acc;
  logic [STAT_WIDTH-1:0] px_beat;
  logic [STAT_WIDTH-1:0] px_total;
  logic                  px_sample_valid;

  assign px_beat         = px_valid_i ? STAT_WIDTH'(px_cnt_i) : '0;
  assign px_total        = sat_inc(px_acc, px_beat);
  assign px_sample_valid = line_end_i && in_line;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_line <= 1'b0;
      px_acc  <= '0;
    end else if (line_start_i) begin
      in_line <= 1'b1;
      px_acc  <= px_beat;
    end else if (in_line) begin
      px_acc <= px_total;
      if (line_end_i) in_line <= 1'b0;
    end
  end

  csi2_minmax_tracker u_ln_tracker (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clear_i        (clear_stat_i),
    .sample_i       (ln_total),
    .sample_valid_i (ln_sample_valid),
    .min_o          (min_ln_per_frame_o),
    .max_o          (max_ln_per_frame_o)
  );

  csi2_minmax_tracker u_px_tracker (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clear_i        (clear_stat_i),
    .sample_i       (px_total),
    .sample_valid_i (px_sample_valid),
    .min_o          (min_px_per_ln_o),
    .max_o          (max_px_per_ln_o)
  );

`ifdef CSI2_STAT_FPS_EN
  localparam int WIN_W = $clog2(CLK_FREQ_HZ);

  logic [WIN_W-1:0]      win_cnt;
  logic [STAT_WIDTH-1:0] frm_cnt;
  logic                  win_wrap;

  assign win_wrap = (win_cnt == WIN_W'(CLK_FREQ_HZ - 1));

  // The window keeps running through clear; only the published value is zeroed.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      win_cnt <= '0;
      frm_cnt <= '0;
      fps_o   <= '0;
    end else begin
      if (win_wrap) begin
        win_cnt <= '0;
        frm_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (frame_end_i) frm_cnt <= sat_inc(frm_cnt, ONE);
      end
      if (clear_stat_i)  fps_o <= '0;
      else if (win_wrap) fps_o <= sat_inc(frm_cnt, STAT_WIDTH'(frame_end_i));
    end
  end
`else
  assign fps_o = '0;
`endif

endmodule
